// File: rtl/merkle_pair_feeder.sv
// merkle_pair_feeder
//
// Groups a stream of 256-bit hashes for one Merkle-tree level into 512-bit
// {left, right} pairs for the double-SHA256 processing element. If a level
// has an odd number of hashes, the last hash is paired with itself (Bitcoin
// rule). Pairs leave over a valid/ready handshake. The block counts pairs
// per level and pulses level_done once the level's last pair is taken.
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   reset        synchronous, active-high
//   level_start  one-cycle pulse, latches leaf_count (honoured only in IDLE)
//   leaf_count   number of hashes in the level (legal 2..2^CNT_W-1)
//   hash_in      incoming hash, passed through unmodified
//   hash_valid   hash_in valid
//   hash_ready   block accepts hash_in this cycle
//   pair_out     {left[511:256], right[255:0]}
//   pair_valid   pair_out valid
//   pair_ready   downstream accepts pair_out
//   pair_idx     0-based index of the pair presented / next to be presented
//   pairs_total  ceil(leaf_count/2), latched at level_start
//   busy         state != IDLE
//   level_done   one-cycle pulse after the last pair is accepted
//   cfg_err      one-cycle pulse when level_start arrives with leaf_count < 2

module merkle_pair_feeder #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             level_start,
  input  logic [CNT_W-1:0] leaf_count,
  input  logic [255:0]     hash_in,
  input  logic             hash_valid,
  output logic             hash_ready,
  output logic [511:0]     pair_out,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [CNT_W-1:0] pair_idx,
  output logic [CNT_W-1:0] pairs_total,
  output logic             busy,
  output logic             level_done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_LEFT  = 3'd1,
    GET_RIGHT = 3'd2,
    EMIT      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [255:0]     left;
  logic [255:0]     right;
  logic             hash_take;

  // Handshake flags come straight from the state register, so pair_ready
  // never reaches hash_ready combinationally.
  assign hash_ready = (state == GET_LEFT) || (state == GET_RIGHT);
  assign pair_valid = (state == EMIT);
  assign busy       = (state != IDLE);
  assign level_done = (state == DONE);
  assign pair_out   = {left, right};
  assign hash_take  = hash_valid && hash_ready;

  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge, and every register including
    // the 256-bit data holders is cleared so pair_out reads zero after reset.
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      left        <= '0;
      right       <= '0;
      pair_idx    <= '0;
      pairs_total <= '0;
      cfg_err     <= 1'b0;
    end else begin
      // NOTE: all state updates are non-blocking so every register samples
      // the pre-edge values, independent of statement order.
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (level_start) begin
            if (leaf_count < CNT_W'(2)) begin
              cfg_err <= 1'b1;
            end else begin
              remaining <= leaf_count;
              // ceil(n/2) written as floor(n/2) + lsb so it cannot overflow
              pairs_total <= (leaf_count >> 1) + CNT_W'(leaf_count[0]);
              pair_idx    <= '0;
              state       <= GET_LEFT;
            end
          end
        end

        GET_LEFT: begin
          if (hash_take) begin
            left      <= hash_in;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              // Odd tail: the last hash is paired with itself.
              right <= hash_in;
              state <= EMIT;
            end else begin
              state <= GET_RIGHT;
            end
          end
        end

        GET_RIGHT: begin
          if (hash_take) begin
            right     <= hash_in;
            remaining <= remaining - CNT_W'(1);
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (pair_ready) begin
            if (remaining == '0) begin
              state <= DONE;
            end else begin
              pair_idx <= pair_idx + CNT_W'(1);
              state    <= GET_LEFT;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merkle_pair_feeder.sv
// Self-checking bench for merkle_pair_feeder. Expected pairs are built from
// the hash list with the pairing rule (h[2p], h[2p+1] or h[2p] duplicated),
// and level latency from 1 + 3*floor(n/2) + 2*(n mod 2) plus any stalls.

module tb_merkle_pair_feeder;

  localparam int CNT_W = 16;

  logic             CLK;
  logic             reset;
  logic             level_start;
  logic [CNT_W-1:0] leaf_count;
  logic [255:0]     hash_in;
  logic             hash_valid;
  logic             hash_ready;
  logic [511:0]     pair_out;
  logic             pair_valid;
  logic             pair_ready;
  logic [CNT_W-1:0] pair_idx;
  logic [CNT_W-1:0] pairs_total;
  logic             busy;
  logic             level_done;
  logic             cfg_err;

  int checks   = 0;
  int failures = 0;

  merkle_pair_feeder #(.CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .level_start (level_start),
    .leaf_count  (leaf_count),
    .hash_in     (hash_in),
    .hash_valid  (hash_valid),
    .hash_ready  (hash_ready),
    .pair_out    (pair_out),
    .pair_valid  (pair_valid),
    .pair_ready  (pair_ready),
    .pair_idx    (pair_idx),
    .pairs_total (pairs_total),
    .busy        (busy),
    .level_done  (level_done),
    .cfg_err     (cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_hash_ready"},  hash_ready,  0);
    check({tag, "_pair_valid"},  pair_valid,  0);
    check({tag, "_pair_out"},    pair_out,    0);
    check({tag, "_pair_idx"},    pair_idx,    0);
    check({tag, "_pairs_total"}, pairs_total, 0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_level_done"},  level_done,  0);
    check({tag, "_cfg_err"},     cfg_err,     0);
  endtask

  // Runs one level of n hashes. vpct/rpct: percent chance hash_valid /
  // pair_ready are offered. stall: cycles pair_ready is held low after each
  // pair first appears. poke: fire level_start while the level is running.
  task automatic run_level(input int n, input int vpct, input int rpct,
                           input int stall, input bit poke);
    logic [255:0] h[$];
    logic [511:0] ex[$];
    int hidx = 0;
    int pidx = 0;
    int c;
    int stall_left;
    int npairs;
    int exp_cycles;
    bit done = 0;

    for (int i = 0; i < n; i++) h.push_back(rand_hash());
    for (int p = 0; 2 * p < n; p++)
      ex.push_back({h[2*p], (2*p + 1 < n) ? h[2*p+1] : h[2*p]});
    npairs = ex.size();

    @(negedge CLK);
    level_start = 1'b1;
    leaf_count  = CNT_W'(n);
    hash_valid  = 1'b0;
    pair_ready  = 1'b0;
    @(negedge CLK);
    level_start = 1'b0;
    c = 1;
    stall_left = stall;
    check("pairs_total_latched", pairs_total, npairs);
    check("hash_ready_first", hash_ready, 1);

    while (!done && c < 4000) begin
      if (level_done) begin
        done = 1;
      end else begin
        check("busy_in_level", busy, 1);
        check("no_cfg_err", cfg_err, 0);
        check("ready_valid_excl", hash_ready & pair_valid, 0);

        level_start = poke && (c == 2 || c == 4);
        leaf_count  = (c == 2) ? CNT_W'(1) : CNT_W'(8);

        if (hash_ready && hidx < n) begin
          hash_valid = ($urandom_range(99) < vpct);
          hash_in    = h[hidx];
          if (hash_valid) hidx++;
        end else begin
          hash_valid = $urandom_range(1);
          hash_in    = rand_hash();
        end

        if (pair_valid) begin
          if (pidx < npairs) begin
            check("pair_out", pair_out, ex[pidx]);
            check("pair_idx", pair_idx, pidx);
          end else begin
            check("extra_pair", pidx, npairs - 1);
          end
          if (stall_left > 0) begin
            pair_ready = 1'b0;
            stall_left--;
          end else begin
            pair_ready = ($urandom_range(99) < rpct);
          end
          if (pair_ready) begin
            pidx++;
            stall_left = stall;
          end
        end else begin
          pair_ready = $urandom_range(1);
        end

        @(negedge CLK);
        c++;
      end
    end

    level_start = 1'b0;
    hash_valid  = 1'b0;
    pair_ready  = 1'b0;
    check("level_done_seen", done, 1);
    check("pairs_accepted", pidx, npairs);
    check("hashes_consumed", hidx, n);
    check("pair_idx_last", pair_idx, npairs - 1);
    check("pairs_total_kept", pairs_total, npairs);
    if (vpct == 100 && rpct == 100) begin
      exp_cycles = 1 + 3 * (n / 2) + 2 * (n % 2) + stall * npairs;
      check("start_to_done_cycles", c, exp_cycles);
    end
    @(negedge CLK);
    check("level_done_one_cycle", level_done, 0);
    check("idle_after_done", busy, 0);
    check("pair_idx_held", pair_idx, npairs - 1);
  endtask

  task automatic cfg_test(input int n);
    @(negedge CLK);
    level_start = 1'b1;
    leaf_count  = CNT_W'(n);
    @(negedge CLK);
    level_start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    check("cfg_err_hash_ready", hash_ready, 0);
    @(negedge CLK);
    check("cfg_err_one_cycle", cfg_err, 0);
    check("cfg_err_still_idle", busy, 0);
  endtask

  initial begin
    logic [255:0] h0;
    reset       = 1'b1;
    level_start = 1'b0;
    leaf_count  = '0;
    hash_in     = '0;
    hash_valid  = 1'b0;
    pair_ready  = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    check_reset_vals("reset");

    // Even and odd levels, no stalls, exact latency.
    run_level(4, 100, 100, 0, 1'b0);
    run_level(3, 100, 100, 0, 1'b0);
    run_level(2, 100, 100, 0, 1'b0);

    // Backpressure: five cycles of pair_ready low on an n=2 level.
    run_level(2, 100, 100, 5, 1'b0);

    // Illegal leaf counts.
    cfg_test(0);
    cfg_test(1);

    // level_start while busy is ignored.
    run_level(4, 100, 100, 0, 1'b1);

    // Largest count: pairs_total must not overflow; then abort by reset.
    @(negedge CLK);
    level_start = 1'b1;
    leaf_count  = CNT_W'(65535);
    @(negedge CLK);
    level_start = 1'b0;
    check("max_pairs_total", pairs_total, 32768);
    check("max_busy", busy, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check_reset_vals("abort_max");

    // Reset during GET_RIGHT discards the partial pair.
    h0 = rand_hash();
    @(negedge CLK);
    level_start = 1'b1;
    leaf_count  = CNT_W'(4);
    @(negedge CLK);
    level_start = 1'b0;
    hash_valid  = 1'b1;
    hash_in     = h0;
    @(negedge CLK);
    hash_valid = 1'b0;
    check("mid_hash_ready", hash_ready, 1);
    check("mid_no_pair", pair_valid, 0);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check_reset_vals("mid_reset");
    run_level(2, 100, 100, 0, 1'b0);

    // Randomly gapped hash stream, odd level.
    run_level(5, 50, 100, 0, 1'b0);

    // A few random levels with random gaps on both sides.
    for (int k = 0; k < 4; k++)
      run_level($urandom_range(2, 9), 60, 60, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
